// File: rtl/nbbpu_pkg.sv
// rtl/nbbpu_pkg.sv - shared register-file sizes, lane encodings and write-request type
package nbbpu_pkg;

    localparam int NUM_REGS   = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 16;

    // {upper, lower} byte-enable encodings
    localparam logic [1:0] LANES_NONE  = 2'b00;
    localparam logic [1:0] LANES_LOWER = 2'b01;
    localparam logic [1:0] LANES_UPPER = 2'b10;
    localparam logic [1:0] LANES_FULL  = 2'b11;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            lanes;
    } wb_req_t;

    // Producers deliver lane-positioned data; the regfile expects a lone
    // byte in [7:0], so an upper-only write is shifted down.
    function automatic logic [DATA_WIDTH-1:0] align_lanes(
        input logic [DATA_WIDTH-1:0] data,
        input logic [1:0]            lanes
    );
        case (lanes)
            LANES_FULL:  align_lanes = data;
            LANES_LOWER: align_lanes = {{(DATA_WIDTH/2){1'b0}}, data[DATA_WIDTH/2-1:0]};
            LANES_UPPER: align_lanes = {{(DATA_WIDTH/2){1'b0}}, data[DATA_WIDTH-1:DATA_WIDTH/2]};
            LANES_NONE:  align_lanes = data;  // nothing is written; value is don't-care
        endcase
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register pending-write scoreboard with overlap detection
// Ports:
//   clock, reset_n                  clock and async active-low reset
//   reserve_valid, reserve_addr     decode reserves a destination (addr 0 ignored)
//   clear_valid, clear_addr         output stage retires a write this edge
//   query_addr_1/2, pending_1/2     source lookups (addr 0 never pending)
//   overlap_error                   sticky: reserve of a still-pending register
module wb_scoreboard
    import nbbpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  reserve_valid,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    input  logic                  clear_valid,
    input  logic [ADDR_WIDTH-1:0] clear_addr,
    input  logic [ADDR_WIDTH-1:0] query_addr_1,
    input  logic [ADDR_WIDTH-1:0] query_addr_2,
    output logic                  pending_1,
    output logic                  pending_2,
    output logic                  overlap_error
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic                reserve_live;
    logic                clear_same;

    always_comb begin
        reserve_live = reserve_valid && (reserve_addr != '0);
        clear_same   = clear_valid && (clear_addr == reserve_addr);
    end

    // Clear first, then set, so a reserve on the retiring edge keeps the bit.
    always_comb begin
        pending_next = pending;
        if (clear_valid) begin
            pending_next[clear_addr] = 1'b0;
        end
        if (reserve_live) begin
            pending_next[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending       <= '0;
            overlap_error <= 1'b0;
        end else begin
            pending <= pending_next;
            // A register being retired on this very edge is not an overlap.
            if (reserve_live && pending[reserve_addr] && !clear_same) begin
                overlap_error <= 1'b1;
            end
        end
    end

    assign pending_1 = (query_addr_1 != '0) && pending[query_addr_1];
    assign pending_2 = (query_addr_2 != '0) && pending[query_addr_2];

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - NBBPU regfile write-side arbiter, lane aligner and scoreboard
// Optional feature macro: NBBPU_WB_BYPASS_EN (adds bypass_hit_n / bypass_data_n outputs)
// Ports:
//   clock, reset_n                          clock and async active-low reset
//   alu_valid/ready/addr/data/lanes         ALU result write (stalls behind mem)
//   mem_valid/addr/data/lanes               load return write (never stalls)
//   reserve_valid, reserve_addr             decode destination reservation
//   query_addr_n, query_busy_n              decode source hazard lookup
//   write_lower/upper_enable, address_write, write_data   registered regfile port
//   overlap_error, commit_count             sticky error and saturating commit count
module regfile_writeback
    import nbbpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [1:0]            alu_lanes,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [1:0]            mem_lanes,
    input  logic                  reserve_valid,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    input  logic [ADDR_WIDTH-1:0] query_addr_1,
    input  logic [ADDR_WIDTH-1:0] query_addr_2,
    output logic                  query_busy_1,
    output logic                  query_busy_2,
    output logic                  write_lower_enable,
    output logic                  write_upper_enable,
    output logic [ADDR_WIDTH-1:0] address_write,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  overlap_error,
    output logic [15:0]           commit_count
`ifdef NBBPU_WB_BYPASS_EN
    ,
    output logic                  bypass_hit_1,
    output logic                  bypass_hit_2,
    output logic [DATA_WIDTH-1:0] bypass_data_1,
    output logic [DATA_WIDTH-1:0] bypass_data_2
`endif
);

    wb_req_t acc_req;
    logic    acc_valid;
    logic    out_valid;
    logic    pending_1;
    logic    pending_2;

    // Load returns cannot be back-pressured, so mem always wins.
    assign alu_ready = !mem_valid;

    always_comb begin
        acc_valid = mem_valid || alu_valid;
        if (mem_valid) begin
            acc_req = '{addr: mem_addr, data: mem_data, lanes: mem_lanes};
        end else begin
            acc_req = '{addr: alu_addr, data: alu_data, lanes: alu_lanes};
        end
    end

    // Output stage: loaded every cycle, valid only when something was
    // accepted. Address and data hold when idle; enables drop. The commit
    // counter advances as the write enters this stage so it is visible
    // alongside the enables.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid          <= 1'b0;
            write_lower_enable <= 1'b0;
            write_upper_enable <= 1'b0;
            address_write      <= '0;
            write_data         <= '0;
            commit_count       <= '0;
        end else begin
            out_valid <= acc_valid;
            if (acc_valid) begin
                address_write      <= acc_req.addr;
                write_data         <= align_lanes(acc_req.data, acc_req.lanes);
                // Register 0 is hardwired: the write retires but never lands.
                write_lower_enable <= acc_req.lanes[0] && (acc_req.addr != '0);
                write_upper_enable <= acc_req.lanes[1] && (acc_req.addr != '0);
                if (commit_count != 16'hFFFF) begin
                    commit_count <= commit_count + 16'd1;
                end
            end else begin
                write_lower_enable <= 1'b0;
                write_upper_enable <= 1'b0;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clock         (clock),
        .reset_n       (reset_n),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .clear_valid   (out_valid),
        .clear_addr    (address_write),
        .query_addr_1  (query_addr_1),
        .query_addr_2  (query_addr_2),
        .pending_1     (pending_1),
        .pending_2     (pending_2),
        .overlap_error (overlap_error)
    );

`ifdef NBBPU_WB_BYPASS_EN
    logic hit_1;
    logic hit_2;

    // Only a full-width write can be forwarded; partial writes still stall.
    assign hit_1 = out_valid && write_lower_enable && write_upper_enable
                   && (address_write == query_addr_1) && (address_write != '0);
    assign hit_2 = out_valid && write_lower_enable && write_upper_enable
                   && (address_write == query_addr_2) && (address_write != '0);

    assign bypass_hit_1  = hit_1;
    assign bypass_hit_2  = hit_2;
    assign bypass_data_1 = write_data;
    assign bypass_data_2 = write_data;
    assign query_busy_1  = pending_1 && !hit_1;
    assign query_busy_2  = pending_2 && !hit_2;
`else
    assign query_busy_1  = pending_1;
    assign query_busy_2  = pending_2;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback
module tb_regfile_writeback;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [3:0]  alu_addr = '0;
    logic [15:0] alu_data = '0;
    logic [1:0]  alu_lanes = '0;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic [1:0]  mem_lanes = '0;
    logic        reserve_valid = 1'b0;
    logic [3:0]  reserve_addr = '0;
    logic [3:0]  query_addr_1 = '0;
    logic [3:0]  query_addr_2 = '0;
    logic        query_busy_1;
    logic        query_busy_2;
    logic        write_lower_enable;
    logic        write_upper_enable;
    logic [3:0]  address_write;
    logic [15:0] write_data;
    logic        overlap_error;
    logic [15:0] commit_count;
`ifdef NBBPU_WB_BYPASS_EN
    logic        bypass_hit_1;
    logic        bypass_hit_2;
    logic [15:0] bypass_data_1;
    logic [15:0] bypass_data_2;
`endif

    always #5 clock = ~clock;

    regfile_writeback dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .alu_valid          (alu_valid),
        .alu_ready          (alu_ready),
        .alu_addr           (alu_addr),
        .alu_data           (alu_data),
        .alu_lanes          (alu_lanes),
        .mem_valid          (mem_valid),
        .mem_addr           (mem_addr),
        .mem_data           (mem_data),
        .mem_lanes          (mem_lanes),
        .reserve_valid      (reserve_valid),
        .reserve_addr       (reserve_addr),
        .query_addr_1       (query_addr_1),
        .query_addr_2       (query_addr_2),
        .query_busy_1       (query_busy_1),
        .query_busy_2       (query_busy_2),
        .write_lower_enable (write_lower_enable),
        .write_upper_enable (write_upper_enable),
        .address_write      (address_write),
        .write_data         (write_data),
        .overlap_error      (overlap_error),
        .commit_count       (commit_count)
`ifdef NBBPU_WB_BYPASS_EN
        ,
        .bypass_hit_1       (bypass_hit_1),
        .bypass_hit_2       (bypass_hit_2),
        .bypass_data_1      (bypass_data_1),
        .bypass_data_2      (bypass_data_2)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend [16];
    bit          m_ovf;
    int unsigned m_count;
    bit          m_ovalid;
    bit          m_lo, m_hi;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    bit          m_data_known;
    bit          t_take;
    logic [3:0]  t_a;
    logic [15:0] t_d;
    logic [1:0]  t_l;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_ovf = 0; m_count = 0; m_ovalid = 0; m_lo = 0; m_hi = 0;
            m_addr = '0; m_data = '0; m_data_known = 1;
        end else begin
            if (reserve_valid && reserve_addr != 0 && m_pend[reserve_addr]
                && !(m_ovalid && m_addr == reserve_addr))
                m_ovf = 1;
            if (m_ovalid) m_pend[m_addr] = 0;
            if (reserve_valid && reserve_addr != 0) m_pend[reserve_addr] = 1;

            t_take = 1;
            if (mem_valid) begin
                t_a = mem_addr; t_d = mem_data; t_l = mem_lanes;
            end else if (alu_valid) begin
                t_a = alu_addr; t_d = alu_data; t_l = alu_lanes;
            end else begin
                t_take = 0;
            end

            m_ovalid = t_take;
            if (t_take) begin
                m_addr = t_a;
                m_lo = (t_l == 2'b01 || t_l == 2'b11) && t_a != 0;
                m_hi = (t_l == 2'b10 || t_l == 2'b11) && t_a != 0;
                m_data_known = (t_l != 2'b00);
                if (t_l == 2'b11) m_data = t_d;
                else if (t_l == 2'b01) m_data = t_d & 16'h00FF;
                else m_data = t_d >> 8;
                if (m_count < 65535) m_count = m_count + 1;
            end else begin
                m_lo = 0; m_hi = 0;
            end
        end
    end

    function automatic bit exp_hit(input logic [3:0] q);
        return m_ovalid && m_lo && m_hi && m_addr == q && q != 0;
    endfunction

    function automatic bit exp_busy(input logic [3:0] q);
        bit b;
        b = (q != 0) && m_pend[q];
`ifdef NBBPU_WB_BYPASS_EN
        if (exp_hit(q)) b = 0;
`endif
        return b;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (reset_n) begin
            chk("alu_ready", alu_ready, !mem_valid);
            chk("write_lower_enable", write_lower_enable, m_lo);
            chk("write_upper_enable", write_upper_enable, m_hi);
            chk("address_write", address_write, m_addr);
            if (m_data_known) chk("write_data", write_data, m_data);
            chk("query_busy_1", query_busy_1, exp_busy(query_addr_1));
            chk("query_busy_2", query_busy_2, exp_busy(query_addr_2));
            chk("overlap_error", overlap_error, m_ovf);
            chk("commit_count", commit_count, m_count);
`ifdef NBBPU_WB_BYPASS_EN
            chk("bypass_hit_1", bypass_hit_1, exp_hit(query_addr_1));
            chk("bypass_hit_2", bypass_hit_2, exp_hit(query_addr_2));
            if (exp_hit(query_addr_1)) chk("bypass_data_1", bypass_data_1, m_data);
            if (exp_hit(query_addr_2)) chk("bypass_data_2", bypass_data_2, m_data);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0; reserve_valid = 0;
    endtask

    task automatic alu_req(input logic [3:0] a, input logic [15:0] d, input logic [1:0] l);
        alu_valid = 1; alu_addr = a; alu_data = d; alu_lanes = l;
    endtask

    initial begin
        idle();
        repeat (2) step();
        chk("reset lower_en", write_lower_enable, 0);
        chk("reset upper_en", write_upper_enable, 0);
        chk("reset addr", address_write, 0);
        chk("reset data", write_data, 0);
        chk("reset count", commit_count, 0);
        chk("reset overlap", overlap_error, 0);
        reset_n = 1;
        step();

        // ALU full write
        alu_req(4'd3, 16'hBEEF, 2'b11);
        #1 chk("t1 alu_ready", alu_ready, 1);
        step(); idle();
        chk("t1 lower_en", write_lower_enable, 1);
        chk("t1 upper_en", write_upper_enable, 1);
        chk("t1 addr", address_write, 3);
        chk("t1 data", write_data, 16'hBEEF);
        chk("t1 count", commit_count, 1);

        // mem beats ALU; ALU follows
        mem_valid = 1; mem_addr = 4'd5; mem_data = 16'h12AB; mem_lanes = 2'b10;
        alu_req(4'd6, 16'h3456, 2'b01);
        #1 chk("t2 alu_ready", alu_ready, 0);
        step(); mem_valid = 0;
        chk("t2 lower_en", write_lower_enable, 0);
        chk("t2 upper_en", write_upper_enable, 1);
        chk("t2 addr", address_write, 5);
        chk("t2 data", write_data, 16'h0012);
        step(); idle();
        chk("t2b addr", address_write, 6);
        chk("t2b data", write_data, 16'h0056);
        chk("t2b lower_en", write_lower_enable, 1);
        chk("t2b count", commit_count, 3);

        // reserve / clear / same-edge re-reserve
        reserve_valid = 1; reserve_addr = 4'd7;
        step(); reserve_valid = 0; query_addr_1 = 4'd7;
        #1 chk("t3 busy set", query_busy_1, 1);
        alu_req(4'd7, 16'h1111, 2'b11);
        step(); idle();
        reserve_valid = 1; reserve_addr = 4'd7;
        step(); reserve_valid = 0;
        chk("t3 busy kept", query_busy_1, 1);
        chk("t3 no overlap", overlap_error, 0);
        alu_req(4'd7, 16'h2222, 2'b11);
        step(); idle();
        step();
        chk("t3 busy cleared", query_busy_1, 0);

        // double reserve -> sticky overlap
        reserve_valid = 1; reserve_addr = 4'd4;
        step(); step(); reserve_valid = 0;
        chk("t4 overlap", overlap_error, 1);
        repeat (3) step();
        chk("t4 overlap sticky", overlap_error, 1);

        // register 0
        alu_req(4'd0, 16'hFFFF, 2'b11);
        step(); idle();
        chk("t5 lower_en r0", write_lower_enable, 0);
        chk("t5 upper_en r0", write_upper_enable, 0);
        chk("t5 count", commit_count, 6);
        reserve_valid = 1; reserve_addr = 4'd0;
        step(); reserve_valid = 0; query_addr_2 = 4'd0;
        #1 chk("t5 busy r0", query_busy_2, 0);

        // async reset mid-flight
        reserve_valid = 1; reserve_addr = 4'd9;
        alu_req(4'd9, 16'hA5A5, 2'b11);
        step(); idle();
        chk("t6 in flight", write_lower_enable, 1);
        reset_n = 0;
        #1;
        chk("t6 async lower_en", write_lower_enable, 0);
        chk("t6 async upper_en", write_upper_enable, 0);
        step();
        reset_n = 1;
        query_addr_1 = 4'd9;
        #1;
        chk("t6 pending cleared", query_busy_1, 0);
        chk("t6 count cleared", commit_count, 0);
        chk("t6 overlap cleared", overlap_error, 0);
        step();

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            mem_valid     = ($urandom_range(0, 9) < 3);
            mem_addr      = 4'($urandom);
            mem_data      = 16'($urandom);
            mem_lanes     = 2'($urandom);
            alu_valid     = ($urandom_range(0, 9) < 5);
            alu_addr      = 4'($urandom);
            alu_data      = 16'($urandom);
            alu_lanes     = 2'($urandom);
            reserve_valid = ($urandom_range(0, 9) < 3);
            reserve_addr  = 4'($urandom);
            query_addr_1  = 4'($urandom);
            query_addr_2  = 4'($urandom);
            if (i == 1500) begin
                reset_n = 0;
                #2 reset_n = 1;
            end
            step();
        end
        idle();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side controller for the NBBPU 16 x 16-bit register file.
- Accepts result writes from two producers: ALU/execute and the memory load return path. Arbitrates between them, aligns the byte lanes, and drives the regfile write port from registered outputs.
- Keeps a per-register pending scoreboard. Decode reserves destinations at issue; hazards are reported back to decode.

Parameters:
- NUM_REGS, 16, number of architectural registers (power of two)
- ADDR_WIDTH, 4, log2(NUM_REGS)
- DATA_WIDTH, 16, register width (two 8-bit lanes)

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU write request valid
- alu_ready  output  1  ALU request accepted this cycle when high with alu_valid
- alu_addr  input  4  ALU destination register
- alu_data  input  16  ALU result, lane-positioned (upper byte in [15:8])
- alu_lanes  input  2  {upper, lower} byte enables
- mem_valid  input  1  load return valid (cannot stall)
- mem_addr  input  4  load destination register
- mem_data  input  16  load data, lane-positioned
- mem_lanes  input  2  {upper, lower} byte enables
- reserve_valid  input  1  decode reserves a destination register
- reserve_addr  input  4  register being reserved
- query_addr_1  input  4  decode source 1 register
- query_addr_2  input  4  decode source 2 register
- query_busy_1  output  1  source 1 has a pending write
- query_busy_2  output  1  source 2 has a pending write
- write_lower_enable  output  1  to regfile
- write_upper_enable  output  1  to regfile
- address_write  output  4  to regfile
- write_data  output  16  to regfile (regfile byte convention)
- overlap_error  output  1  sticky: reserve hit an already-pending register
- commit_count  output  16  saturating count of committed writes

Behaviour:
- Reset (async, reset_n low): all outputs 0, pending[] all 0, overlap_error 0, commit_count 0. Any in-flight write is discarded.
- Arbitration:
  - mem has fixed priority; mem input has no ready signal and is always accepted.
  - alu_ready = !mem_valid (combinational).
  - Exactly one request is accepted per cycle.
- Pipeline:
  - The accepted request is registered into the output stage at the next clock edge. Enables are asserted during that following cycle, and the regfile commits on the edge after.
  - Accept-to-commit latency is 2 edges.
  - The output stage drains every cycle. With no accepted request, the enables are 0 the next cycle; address_write and write_data hold their previous values.
- Lane alignment (regfile convention):
  - lanes=2'b11: write_data = data.
  - lanes=2'b01: write_data = {8'h00, data[7:0]}.
  - lanes=2'b10: write_data = {8'h00, data[15:8]}, i.e. the upper byte is moved to [7:0].
  - lanes=2'b00: no enables asserted, but still counted as a commit and still clears pending.
- Register 0:
  - Writes to addr 0 are accepted, but both enables are forced to 0.
  - reserve of addr 0 is ignored.
  - query of addr 0 always returns busy=0.
- Scoreboard:
  - pending[reserve_addr] is set at the edge where reserve_valid is high.
  - pending[address_write] is cleared at the edge where the output stage holds a valid write.
  - If a reserve and a clear target the same register on the same edge, the set wins and pending stays 1.
  - query_busy_n = pending[query_addr_n], combinational from the registered state.
- overlap_error: set when reserve_valid targets a register with pending=1 that is not being cleared that same edge. Cleared only by reset.
- commit_count: increments once per valid output-stage cycle; saturates at 16'hFFFF.
- Does not check that writes match reservations: a write to a non-pending register commits normally.

Optional Feature:
- Macro: NBBPU_WB_BYPASS_EN.
- Defined:
  - Adds outputs bypass_hit_1, bypass_hit_2 (1 bit) and bypass_data_1, bypass_data_2 (16 bits).
  - bypass_hit_n = 1 when the output stage is valid, has both lanes enabled, address_write == query_addr_n, and address_write != 0.
  - bypass_data_n = write_data.
  - On a hit, query_busy_n is forced to 0.
- Undefined: those ports are absent and query_busy is pure scoreboard.

Decomposition:
- Package nbbpu_pkg holds:
  - NUM_REGS, ADDR_WIDTH, DATA_WIDTH
  - lane-encoding constants LANES_NONE/LOWER/UPPER/FULL
  - a write-request struct {addr, data, lanes}
- One natural sub-module: wb_scoreboard. It holds the pending vector, set/clear priority, query muxes and overlap_error.
- Arbitration, alignment, output stage and counter stay in the top level.

Test Plan:
- Reset, then alu_valid with addr=3, data=16'hBEEF, lanes=11 -> alu_ready=1. Next cycle: both enables=1, address_write=3, write_data=16'hBEEF. commit_count=1.
- Same cycle: mem_valid (addr=5, data=16'h12AB, lanes=10) and alu_valid (addr=6) -> alu_ready=0. Next cycle: upper enable only, address_write=5, write_data=16'h0012. The ALU write follows one cycle after mem_valid drops.
- reserve addr=7, then query_addr_1=7 -> busy=1. An ALU write to 7 commits and busy returns to 0 the cycle after the output stage. A reserve of 7 on that same clearing edge keeps busy=1 with overlap_error=0.
- reserve addr=4 twice with no write in between -> overlap_error=1, and it stays 1 until reset_n pulses low.
- ALU write to addr=0 (data=16'hFFFF, lanes=11) -> both enables 0, commit_count increments. reserve addr 0 then query addr 0 -> busy=0.
- Assert reset_n low mid-flight while the output stage is valid -> enables drop to 0 immediately (async), and pending and commit_count read 0 after release.
